// File: rtl/alarm_bank.sv
// Multi-channel HH:MM alarm store with arm/ring/timeout handling and BCD display of the selected channel.
// Define ALARM_BANK_SNOOZE_EN to enable the snooze path; otherwise the snooze input is ignored.
module alarm_bank #(
  parameter int unsigned NUM_ALARMS   = 2,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned RING_TIMEOUT = 5,
  parameter int unsigned SNOOZE_MIN   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  adjust_enable_minutes,
  input  logic                  adjust_enable_hours,
  input  logic                  Up_down,
  input  logic                  arm_toggle,
  input  logic                  snooze,
  input  logic                  minute_tick,
  input  logic [5:0]            cur_minutes,
  input  logic [4:0]            cur_hours,
  output logic [3:0]            minutes_units,
  output logic [2:0]            minutes_tenth,
  output logic [3:0]            hours_units,
  output logic [1:0]            hours_tenth,
  output logic [NUM_ALARMS-1:0] armed_mask,
  output logic [NUM_ALARMS-1:0] ring_mask,
  output logic                  ringing
);

  typedef enum logic [1:0] {StDisarmed, StArmed, StRinging, StSnoozed} state_e;

  localparam logic [5:0] RingInit   = 6'(RING_TIMEOUT);
  localparam logic [5:0] SnoozeInit = 6'(SNOOZE_MIN);

  state_e     state_q [NUM_ALARMS];
  state_e     state_d [NUM_ALARMS];
  logic [5:0] min_q   [NUM_ALARMS];
  logic [5:0] min_d   [NUM_ALARMS];
  logic [4:0] hr_q    [NUM_ALARMS];
  logic [4:0] hr_d    [NUM_ALARMS];
  logic [5:0] tmr_q   [NUM_ALARMS];
  logic [5:0] tmr_d   [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] sel_hit;
  logic                  snooze_act;
  logic [5:0]            min_sel;
  logic [4:0]            hr_sel;

`ifdef ALARM_BANK_SNOOZE_EN
  assign snooze_act = snooze;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snooze_act    = 1'b0;
`endif

  // Out-of-range selects match no channel, so adjust/arm are dropped and the display reads 0.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      sel_hit[i] = (sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= StDisarmed;
        min_q[i]   <= '0;
        hr_q[i]    <= '0;
        tmr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= state_d[i];
        min_q[i]   <= min_d[i];
        hr_q[i]    <= hr_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      min_d[i]   = min_q[i];
      hr_d[i]    = hr_q[i];

      if (arm_toggle && sel_hit[i]) begin
        case (state_q[i])
          StDisarmed: state_d[i] = StArmed;
          StArmed:    state_d[i] = StDisarmed;
          default:    state_d[i] = StArmed;
        endcase
        tmr_d[i] = '0;
      end else if (snooze_act && (state_q[i] == StRinging)) begin
        state_d[i] = StSnoozed;
        tmr_d[i]   = SnoozeInit;
      end else if (minute_tick) begin
        case (state_q[i])
          StArmed: begin
            if ({hr_q[i], min_q[i]} == {cur_hours, cur_minutes}) begin
              state_d[i] = StRinging;
              tmr_d[i]   = RingInit;
            end
          end
          StRinging: begin
            if (tmr_q[i] == 6'd1) begin
              state_d[i] = StArmed;
              tmr_d[i]   = '0;
            end else begin
              tmr_d[i] = tmr_q[i] - 6'd1;
            end
          end
          StSnoozed: begin
            if (tmr_q[i] == 6'd1) begin
              state_d[i] = StRinging;
              tmr_d[i]   = RingInit;
            end else begin
              tmr_d[i] = tmr_q[i] - 6'd1;
            end
          end
          default: ;
        endcase
      end

      // Time fields are frozen while ringing or snoozed; compare above already used the old value.
      if (sel_hit[i] && !arm_toggle &&
          ((state_q[i] == StDisarmed) || (state_q[i] == StArmed))) begin
        if (adjust_enable_minutes) begin
          if (Up_down) min_d[i] = (min_q[i] == 6'd59) ? 6'd0 : min_q[i] + 6'd1;
          else         min_d[i] = (min_q[i] == 6'd0) ? 6'd59 : min_q[i] - 6'd1;
        end
        if (adjust_enable_hours) begin
          if (Up_down) hr_d[i] = (hr_q[i] == 5'd23) ? 5'd0 : hr_q[i] + 5'd1;
          else         hr_d[i] = (hr_q[i] == 5'd0) ? 5'd23 : hr_q[i] - 5'd1;
        end
      end
    end
  end

  always_comb begin
    armed_mask = '0;
    ring_mask  = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      armed_mask[i] = (state_q[i] != StDisarmed);
      ring_mask[i]  = (state_q[i] == StRinging);
    end
    ringing = |ring_mask;
  end

  always_comb begin
    min_sel = '0;
    hr_sel  = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel_hit[i]) begin
        min_sel = min_q[i];
        hr_sel  = hr_q[i];
      end
    end
  end

  assign minutes_tenth = 3'(min_sel / 6'd10);
  assign minutes_units = 4'(min_sel % 6'd10);
  assign hours_tenth   = 2'(hr_sel / 5'd10);
  assign hours_units   = 4'(hr_sel % 5'd10);

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboarded random + directed bench for alarm_bank against a flag/counter reference model.
module tb_alarm_bank;
  localparam int NCH = 2;
  localparam int SW  = 2;
  localparam int RT  = 5;
  localparam int SM  = 9;
`ifdef ALARM_BANK_SNOOZE_EN
  localparam bit SnzEn = 1'b1;
`else
  localparam bit SnzEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [SW-1:0]  sel = '0;
  logic           am = 1'b0, ah = 1'b0, ud = 1'b0, at = 1'b0, sn = 1'b0, tk = 1'b0;
  logic [5:0]     cm = '0;
  logic [4:0]     chr = '0;
  logic [3:0]     mu, hu;
  logic [2:0]     mt;
  logic [1:0]     ht;
  logic [NCH-1:0] armed_mask, ring_mask;
  logic           ringing;

  alarm_bank #(.NUM_ALARMS(NCH), .SEL_W(SW), .RING_TIMEOUT(RT), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .adjust_enable_minutes(am), .adjust_enable_hours(ah), .Up_down(ud),
    .arm_toggle(at), .snooze(sn), .minute_tick(tk),
    .cur_minutes(cm), .cur_hours(chr),
    .minutes_units(mu), .minutes_tenth(mt), .hours_units(hu), .hours_tenth(ht),
    .armed_mask(armed_mask), .ring_mask(ring_mask), .ringing(ringing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] armed;
    logic [NCH-1:0] ring;
    logic           rng;
    logic [2:0]     mt;
    logic [3:0]     mu;
    logic [1:0]     ht;
    logic [3:0]     hu;
  } exp_t;

  // Reference model: time in plain integers, state as flags plus a ticks-left counter.
  int m_min [NCH];
  int m_hr  [NCH];
  bit m_armed [NCH];
  bit m_ring  [NCH];
  bit m_snz   [NCH];
  int m_left  [NCH];

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(string name, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_min[c] = 0; m_hr[c] = 0; m_armed[c] = 0; m_ring[c] = 0; m_snz[c] = 0; m_left[c] = 0;
    end
  endtask

  task automatic model_step(int s, bit a_m, bit a_h, bit u, bit a_t, bit s_n, bit t_k,
                            int c_m, int c_h);
    for (int c = 0; c < NCH; c++) begin
      bit busy  = m_ring[c] || m_snz[c];
      bit hit   = (s == c);
      bit match = (m_hr[c] * 60 + m_min[c]) == (c_h * 60 + c_m);
      if (a_t && hit) begin
        if (busy) begin m_ring[c] = 0; m_snz[c] = 0; end
        else m_armed[c] = !m_armed[c];
      end else if (SnzEn && s_n && m_ring[c]) begin
        m_ring[c] = 0; m_snz[c] = 1; m_left[c] = SM;
      end else if (t_k) begin
        if (m_ring[c]) begin
          m_left[c]--;
          if (m_left[c] == 0) m_ring[c] = 0;
        end else if (m_snz[c]) begin
          m_left[c]--;
          if (m_left[c] == 0) begin m_snz[c] = 0; m_ring[c] = 1; m_left[c] = RT; end
        end else if (m_armed[c] && match) begin
          m_ring[c] = 1; m_left[c] = RT;
        end
      end
      if (hit && !a_t && !busy) begin
        if (a_m) m_min[c] = u ? (m_min[c] + 1) % 60 : (m_min[c] + 59) % 60;
        if (a_h) m_hr[c]  = u ? (m_hr[c] + 1) % 24 : (m_hr[c] + 23) % 24;
      end
    end
  endtask

  function automatic exp_t expected(int s);
    exp_t e;
    int mv, hv;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      e.armed[c] = m_armed[c];
      e.ring[c]  = m_ring[c];
    end
    e.rng = |e.ring;
    mv = (s < NCH) ? m_min[s] : 0;
    hv = (s < NCH) ? m_hr[s] : 0;
    e.mt = 3'(mv / 10);
    e.mu = 4'(mv % 10);
    e.ht = 2'(hv / 10);
    e.hu = 4'(hv % 10);
    return e;
  endfunction

  task automatic drive(int s, bit a_m, bit a_h, bit u, bit a_t, bit s_n, bit t_k,
                       int c_m, int c_h);
    @(negedge clk);
    sel = SW'(s); am = a_m; ah = a_h; ud = u; at = a_t; sn = s_n; tk = t_k;
    cm = 6'(c_m); chr = 5'(c_h);
    model_step(s, a_m, a_h, u, a_t, s_n, t_k, c_m, c_h);
    exp_q.push_back(expected(s));
  endtask

  task automatic idle(int s);
    drive(s, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(int s, int h, int m);
    drive(s, 0, 0, 0, 0, 0, 1, m, h);
  endtask

  task automatic arm(int s);
    drive(s, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic adj(int s, bit a_m, bit a_h, bit u, int n);
    for (int k = 0; k < n; k++) drive(s, a_m, a_h, u, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every posedge, one queued expectation is matched against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("armed_mask", int'(armed_mask), int'(e.armed));
        chk("ring_mask", int'(ring_mask), int'(e.ring));
        chk("ringing", int'(ringing), int'(e.rng));
        chk("minutes_tenth", int'(mt), int'(e.mt));
        chk("minutes_units", int'(mu), int'(e.mu));
        chk("hours_tenth", int'(ht), int'(e.ht));
        chk("hours_units", int'(hu), int'(e.hu));
      end
    end
  end

  initial begin
    int r, c, h, m;
    model_reset();
    #12;
    chk("reset armed_mask", int'(armed_mask), 0);
    chk("reset ring_mask", int'(ring_mask), 0);
    chk("reset ringing", int'(ringing), 0);
    chk("reset display", int'({mt, mu, ht, hu}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Minute/hour stepping and wrap.
    adj(0, 1, 0, 1, 3);
    adj(0, 1, 0, 0, 3);
    adj(0, 1, 0, 0, 1);
    adj(0, 0, 1, 0, 1);
    adj(0, 0, 1, 1, 1);
    adj(0, 1, 1, 1, 1);

    // ch1 at 07:30 rings and times out.
    adj(1, 0, 1, 1, 7);
    adj(1, 1, 0, 1, 30);
    arm(1);
    tick(1, 7, 30);
    for (int k = 0; k < RT; k++) tick(1, 7, 31);
    idle(1);

    // Both at 06:00 ring together; stopping ch0 keeps it armed.
    adj(0, 0, 1, 1, 6 - m_hr[0]);
    adj(0, 1, 0, 0, m_min[0]);
    adj(1, 0, 1, 0, 1);
    adj(1, 1, 0, 0, 30);
    arm(0);
    tick(0, 6, 0);
    arm(0);
    arm(1);

    // Snooze (or its absence) on both channels.
    tick(0, 6, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < SM; k++) tick(0, 6, 1);
    idle(0);

    // Arm toggle beats a matching tick on a disarmed channel.
    for (int k = 0; k < 3; k++) if (m_armed[0]) arm(0);
    drive(0, 0, 0, 0, 1, 0, 1, 0, 6);
    for (int k = 0; k < 3; k++) if (!m_armed[1] || m_ring[1] || m_snz[1]) arm(1);
    tick(1, 6, 0);
    adj(1, 1, 1, 1, 2);
    idle(1);

    // Asynchronous reset while ringing.
    @(negedge clk);
    chk("ringing before async reset", int'(ringing), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset ringing", int'(ringing), 0);
    chk("async reset ring_mask", int'(ring_mask), 0);
    chk("async reset display", int'({mt, mu, ht, hu}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range select.
    adj(0, 1, 1, 1, 2);
    arm(3);
    adj(3, 1, 1, 1, 1);
    idle(3);
    idle(0);

    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      c = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 1) == 1) begin
        h = m_hr[c]; m = m_min[c];
      end else begin
        h = $urandom_range(0, 23); m = $urandom_range(0, 59);
      end
      if (r < 25)      drive($urandom_range(0, 3), 0, 0, 0, 0, 0, 1, m, h);
      else if (r < 33) drive($urandom_range(0, 3), 0, 0, 0, 1, 0, 0, m, h);
      else if (r < 38) drive($urandom_range(0, 3), 0, 0, 0, 0, 1, 0, m, h);
      else if (r < 80) drive($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                             0, 0, 0, m, h);
      else             drive($urandom_range(0, 3), 0, 0, 0, 0, 0, 0, m, h);
    end
    idle(0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
